// File: rtl/spi_slave_if.sv
// SPI bus pins shared between the board-level master and the spi_slave target.
// Latency: none, plain wiring bundle.
// Backpressure: none; MISO_oe_o exists only when SPI_SLAVE_MISO_OE_EN is defined.
interface spi_slave_if;
    logic SCLK_i;
    logic CS_i;
    logic MOSI_i;
    logic MISO_o;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic MISO_oe_o;
`endif

    modport slave (
        input  SCLK_i,
        input  CS_i,
        input  MOSI_i,
        output MISO_o
`ifdef SPI_SLAVE_MISO_OE_EN
        , output MISO_oe_o
`endif
    );

    modport master (
        output SCLK_i,
        output CS_i,
        output MOSI_i,
        input  MISO_o
`ifdef SPI_SLAVE_MISO_OE_EN
        , input MISO_oe_o
`endif
    );
endinterface

// File: rtl/spi_slave.sv
// SPI target: oversamples SCLK/CS/MOSI in GCLK, receives one left-aligned word per CS-low frame and shifts out a preloaded reply.
// Latency: pin edge to rx_valid_o at most SYNC_STAGES+2 GCLK; MISO follows a launch edge after SYNC_STAGES+1 GCLK.
// Backpressure: none, rx_valid_o is a one-cycle pulse; optional MISO_oe_o output under SPI_SLAVE_MISO_OE_EN.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic [1:0]  spi_mode_i,
    input  logic [1:0]  word_len_i,
    input  logic [31:0] tx_data_i,
    input  logic        tx_load_i,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        busy_o,
    output logic        err_o,
    spi_slave_if.slave  spi
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_d_q, cs_d_q, cs_armed_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   cap_edge, launch_edge;

    logic                   phase_q;
    logic [5:0]             n_q, cnt_q;
    logic [31:0]            tx_shift_q, rx_shift_q, tx_shadow_q, rx_next;
    logic [31:0]            rx_data_q;
    logic                   rx_valid_q, err_q;

    logic                   do_start, do_capture, do_launch, do_abort, do_last;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d_q;
    assign sclk_fall = ~sclk_s & sclk_d_q;
    assign cs_rise   = cs_s & ~cs_d_q;
    // A CS already low when reset is released must not start a frame, so falls count only once CS was seen high.
    assign cs_fall   = ~cs_s & cs_d_q & cs_armed_q;

    assign cap_edge    = phase_q ? sclk_rise : sclk_fall;
    assign launch_edge = phase_q ? sclk_fall : sclk_rise;

    // rx_shift is cleared at frame start, so OR-ing the new bit in place is enough.
    assign rx_next = rx_shift_q | ({31'd0, mosi_s} << (5'd31 - cnt_q[4:0]));

    // Input synchronisers, edge-history flops and the CS arming flag.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_d_q    <= 1'b0;
            cs_d_q      <= 1'b1;
            cs_armed_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.CS_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI_i};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_d_q    <= sclk_s;
            cs_d_q      <= cs_s;
            if (fill_q[SYNC_STAGES-1] && cs_s) begin
                cs_armed_q <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath strobes; a CS rise wins over a same-cycle SCLK edge.
    always_comb begin
        state_d    = state_q;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_launch  = 1'b0;
        do_abort   = 1'b0;
        do_last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    do_start = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else begin
                    if (cap_edge) begin
                        do_capture = 1'b1;
                        if (cnt_q + 6'd1 == n_q) begin
                            do_last = 1'b1;
                            state_d = DONE;
                        end
                    end
                    // A launch before the first capture would drop the MSB, so it is ignored.
                    if (launch_edge && (cnt_q != 6'd0)) begin
                        do_launch = 1'b1;
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, frame settings, tx shadow and the registered status pulses.
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            phase_q     <= 1'b0;
            n_q         <= 6'd0;
            cnt_q       <= 6'd0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            tx_shadow_q <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (tx_load_i) begin
                tx_shadow_q <= tx_data_i;
            end
            if (do_start) begin
                phase_q    <= spi_mode_i[0];
                n_q        <= 6'd32 >> word_len_i;
                cnt_q      <= 6'd0;
                rx_shift_q <= '0;
                tx_shift_q <= tx_load_i ? tx_data_i : tx_shadow_q;
            end
            if (do_capture) begin
                rx_shift_q <= rx_next;
                cnt_q      <= cnt_q + 6'd1;
            end
            if (do_launch) begin
                tx_shift_q <= {tx_shift_q[30:0], 1'b0};
            end
            if (do_last) begin
                rx_data_q <= rx_next;
            end
            rx_valid_q <= do_last;
            err_q      <= (do_start && (sclk_s != spi_mode_i[1])) || do_abort;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE);
    assign spi.MISO_o = (state_q == SHIFT) ? tx_shift_q[31] : 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
    assign spi.MISO_oe_o = (state_q == SHIFT);
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed and random frames driven by a bit-level SPI master model.
// Latency: each SCLK half-period is HP GCLK cycles.
// Backpressure: none; expectations come from a word-level model of the shadow register and masks.
module tb_spi_slave;
    localparam int HP = 8;

    logic        GCLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  spi_mode_i = 2'd0;
    logic [1:0]  word_len_i = 2'd0;
    logic [31:0] tx_data_i = 32'd0;
    logic        tx_load_i = 1'b0;
    logic [31:0] rx_data_o;
    logic        rx_valid_o, busy_o, err_o;

    spi_slave_if spi_bus();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .GCLK       (GCLK),
        .RST        (RST),
        .spi_mode_i (spi_mode_i),
        .word_len_i (word_len_i),
        .tx_data_i  (tx_data_i),
        .tx_load_i  (tx_load_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .spi        (spi_bus)
    );

    always #5 GCLK = ~GCLK;

    int checks = 0;
    int errors = 0;
    int rxv_pulses = 0, rxv_cycles = 0, err_pulses = 0, err_cycles = 0;
    logic rxv_prev = 1'b0, err_prev = 1'b0;
    logic [31:0] exp_shadow = 32'd0;
    logic [31:0] exp_rx = 32'd0;

    // Pulse and pulse-width counters for the one-cycle status outputs.
    always @(negedge GCLK) begin
        if (rx_valid_o === 1'b1) begin
            rxv_cycles++;
            if (!rxv_prev) rxv_pulses++;
        end
        rxv_prev = (rx_valid_o === 1'b1);
        if (err_o === 1'b1) begin
            err_cycles++;
            if (!err_prev) err_pulses++;
        end
        err_prev = (err_o === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge GCLK);
        #1;
    endtask

    function automatic logic [31:0] len_mask(input logic [1:0] len);
        int n;
        n = 32 >> len;
        return (n == 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
    endfunction

    task automatic pulse_load(input logic [31:0] v);
        tx_data_i  = v;
        tx_load_i  = 1'b1;
        exp_shadow = v;
        wait_cyc(1);
        tx_load_i  = 1'b0;
    endtask

    // Bit-level master: captures on the edge whose new level equals the phase bit, launches on the other.
    task automatic frame(input logic [1:0] mode, input logic [1:0] len, input logic [31:0] mosi_w,
                         input int nbits, input logic sclk0, input int load_edge,
                         input logic [31:0] load_val, output logic [31:0] miso_w, output logic busy_mid);
        int caps;
        int edges;
        caps = 0;
        edges = 0;
        miso_w = 32'd0;
        spi_mode_i = mode;
        word_len_i = len;
        spi_bus.SCLK_i = sclk0;
        spi_bus.MOSI_i = mosi_w[31];
        wait_cyc(8);
        spi_bus.CS_i = 1'b0;
        wait_cyc(HP);
        busy_mid = busy_o;
        while (caps < nbits) begin
            if ((!spi_bus.SCLK_i) == mode[0]) begin
                miso_w[31-caps] = spi_bus.MISO_o;
                spi_bus.SCLK_i = ~spi_bus.SCLK_i;
                caps++;
            end else begin
                spi_bus.SCLK_i = ~spi_bus.SCLK_i;
                spi_bus.MOSI_i = mosi_w[31-caps];
            end
            edges++;
            if (edges == load_edge) pulse_load(load_val);
            wait_cyc(HP);
        end
        if (spi_bus.SCLK_i != mode[1]) begin
            spi_bus.SCLK_i = ~spi_bus.SCLK_i;
            wait_cyc(HP);
        end
        spi_bus.CS_i = 1'b1;
        wait_cyc(8);
    endtask

    task automatic full_frame(input string tag, input logic [1:0] mode, input logic [1:0] len,
                              input logic [31:0] mosi_w, input logic sclk0, input int load_edge,
                              input logic [31:0] load_val, input int exp_err);
        logic [31:0] m, exp_tx, miso_w;
        logic busy_mid;
        int p0, e0;
        m = len_mask(len);
        exp_tx = exp_shadow;
        p0 = rxv_pulses;
        e0 = err_pulses;
        frame(mode, len, mosi_w, 32 >> len, sclk0, load_edge, load_val, miso_w, busy_mid);
        exp_rx = mosi_w & m;
        check({tag, "_rx_data"}, rx_data_o, exp_rx);
        check({tag, "_miso_word"}, miso_w & m, exp_tx & m);
        check({tag, "_rx_valid_count"}, 32'(rxv_pulses - p0), 32'd1);
        check({tag, "_err_count"}, 32'(err_pulses - e0), 32'(exp_err));
        check({tag, "_busy_mid_end"}, {30'd0, busy_mid, busy_o}, 32'd2);
    endtask

    initial begin
        logic [31:0] miso_w;
        logic busy_mid;
        logic [1:0] rmode, rlen;
        int p0, e0;

        spi_bus.CS_i = 1'b1;
        spi_bus.SCLK_i = 1'b0;
        spi_bus.MOSI_i = 1'b0;
        RST = 1'b1;
        wait_cyc(3);
        check("reset_rx_data", rx_data_o, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_miso", {31'd0, spi_bus.MISO_o}, 32'd0);
        RST = 1'b0;
        wait_cyc(10);

        pulse_load(32'hA500_0000);
        full_frame("m0_len8", 2'd0, 2'd2, 32'h3C00_0000, 1'b0, 0, 32'd0, 0);

        pulse_load(32'h1234_5678);
        full_frame("m3_len32", 2'd3, 2'd0, 32'hDEAD_BEEF, 1'b1, 0, 32'd0, 0);

        pulse_load(32'h6ABC_DEF0);
        full_frame("m1_len4", 2'd1, 2'd3, 32'h9FFF_FFFF, 1'b0, 0, 32'd0, 0);

        // Abort after 10 of 16 bits.
        p0 = rxv_pulses;
        e0 = err_pulses;
        frame(2'd0, 2'd1, $urandom, 10, 1'b0, 0, 32'd0, miso_w, busy_mid);
        check("abort_err_count", 32'(err_pulses - e0), 32'd1);
        check("abort_rx_valid_count", 32'(rxv_pulses - p0), 32'd0);
        check("abort_rx_data_kept", rx_data_o, exp_rx);
        check("abort_busy_end", {31'd0, busy_o}, 32'd0);
        full_frame("after_abort", 2'd0, 2'd1, $urandom, 1'b0, 0, 32'd0, 0);

        // Reload during a frame only affects the following frames.
        pulse_load(32'hAA00_0000);
        full_frame("load_mid", 2'd0, 2'd2, $urandom, 1'b0, 5, 32'h1100_0000, 0);
        full_frame("load_next", 2'd0, 2'd2, $urandom, 1'b0, 0, 32'd0, 0);
        full_frame("load_resend", 2'd0, 2'd2, $urandom, 1'b0, 0, 32'd0, 0);

        // Mode 2 with SCLK low at CS fall: error pulse but the frame completes.
        full_frame("m2_bad_idle", 2'd2, 2'd2, $urandom, 1'b0, 0, 32'd0, 1);

        for (int i = 0; i < 6; i++) begin
            rmode = 2'($urandom_range(0, 3));
            rlen  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) pulse_load($urandom);
            full_frame("random", rmode, rlen, $urandom, rmode[1], 0, 32'd0, 0);
        end

        // Reset mid-frame with CS held low across reset release.
        pulse_load(32'hF0F0_F0F0);
        spi_mode_i = 2'd0;
        word_len_i = 2'd0;
        spi_bus.SCLK_i = 1'b0;
        spi_bus.MOSI_i = 1'b1;
        wait_cyc(8);
        spi_bus.CS_i = 1'b0;
        wait_cyc(HP);
        for (int k = 0; k < 4; k++) begin
            spi_bus.SCLK_i = ~spi_bus.SCLK_i;
            wait_cyc(HP);
        end
        RST = 1'b1;
        #1;
        check("rst_mid_rx_data", rx_data_o, 32'd0);
        check("rst_mid_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_err", {31'd0, err_o}, 32'd0);
        check("rst_mid_miso", {31'd0, spi_bus.MISO_o}, 32'd0);
        exp_shadow = 32'd0;
        exp_rx = 32'd0;
        wait_cyc(3);
        RST = 1'b0;
        p0 = rxv_pulses;
        e0 = err_pulses;
        wait_cyc(10);
        for (int k = 0; k < 8; k++) begin
            spi_bus.SCLK_i = ~spi_bus.SCLK_i;
            wait_cyc(HP);
        end
        check("cs_low_after_rst_busy", {31'd0, busy_o}, 32'd0);
        spi_bus.CS_i = 1'b1;
        wait_cyc(8);
        check("cs_low_after_rst_pulses", 32'(rxv_pulses - p0 + err_pulses - e0), 32'd0);
        full_frame("post_rst", 2'd0, 2'd2, $urandom, 1'b0, 0, 32'd0, 0);

        check("rx_valid_width", 32'(rxv_cycles), 32'(rxv_pulses));
        check("err_width", 32'(err_cycles), 32'(err_pulses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
